// File: rtl/ddr_burst_sched_pkg.sv
// Shared types and constants for the DDR burst scheduler.
package ddr_sched_pkg;
  typedef enum logic [2:0] {IDLE, ARB, W_XFER, W_CMD, R_CMD, R_XFER, DONE} state_t;

  localparam logic [1:0] CH_WR0 = 2'd0;
  localparam logic [1:0] CH_WR1 = 2'd1;
  localparam logic [1:0] CH_RD0 = 2'd2;
  localparam logic [1:0] CH_RD1 = 2'd3;

  localparam logic [2:0] INSTR_WR = 3'b000;
  localparam logic [2:0] INSTR_RD = 3'b001;
endpackage

// File: rtl/ddr_burst_sched_if.sv
// FIFO status, data-mover handshake and DDR user command port of the scheduler.
interface ddr_burst_sched_if #(
  parameter int ADDR_W = 30,
  parameter int LVL_W  = 10
);
  logic [LVL_W-1:0]  wr0_level, wr1_level, rd0_space, rd1_space;
  logic              xfer_req;
  logic [1:0]        xfer_ch;
  logic              xfer_done;
  logic              cmd_en;
  logic [2:0]        cmd_instr;
  logic [5:0]        cmd_bl;
  logic [ADDR_W-1:0] cmd_byte_addr;
  logic              cmd_full;
  logic              busy;

  modport master (
    input  wr0_level, wr1_level, rd0_space, rd1_space, xfer_done, cmd_full,
    output xfer_req, xfer_ch, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, busy
  );
  modport slave (
    output wr0_level, wr1_level, rd0_space, rd1_space, xfer_done, cmd_full,
    input  xfer_req, xfer_ch, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, busy
  );
endinterface

// File: rtl/vs_edge_sync.sv
// Two-flop synchronizer for an async vsync plus a registered rising-edge pulse.
module vs_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);
  logic [2:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[1:0], async_in};
      pulse <= sync[1] & ~sync[2];
    end
  end
endmodule

// File: rtl/ddr_burst_sched.sv
// Round-robin burst scheduler: 2 camera writers + 2 display readers onto one DDR command port.
// Bank ping-pong is enabled by defining DDR_SCHED_DOUBLE_BUF_EN.
module ddr_burst_sched
  import ddr_sched_pkg::*;
#(
  parameter int                ADDR_W      = 30,
  parameter int                LVL_W       = 10,
  parameter int                BURST_LEN   = 64,
  parameter int                FRAME_WORDS = 98304,
  parameter logic [ADDR_W-1:0] CH0_BASE    = 30'h0000000,
  parameter logic [ADDR_W-1:0] CH1_BASE    = 30'h0800000,
  parameter logic [ADDR_W-1:0] BANK_BYTES  = 30'h0400000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_done,
  input  logic vin1_vs,
  input  logic vin2_vs,
  input  logic vout_vs,
  ddr_burst_sched_if.master bus
);
  localparam int OFF_W = $clog2(FRAME_WORDS + 1);
  localparam logic [OFF_W-1:0] OFF_STEP = OFF_W'(BURST_LEN);
  localparam logic [OFF_W-1:0] OFF_END  = OFF_W'(FRAME_WORDS);
  localparam logic [LVL_W-1:0] LVL_MIN  = LVL_W'(BURST_LEN);

  state_t                  state;
  logic [1:0]              ch, rr, win, idx;
  logic [3:0]              elig;
  logic                    found;
  logic [3:0][OFF_W-1:0]   off;
  logic [OFF_W-1:0]        off_inc, off_nxt;
  logic [ADDR_W-1:0]       win_addr, cmd_addr;
  logic [2:0]              instr;
  logic                    xfer_req, busy;
  logic [2:0]              vs_pulse;
  logic [1:0]              wr_pend, wr_apply;
  logic                    rd_pend, rd_apply, can_apply;

  vs_edge_sync u_vs [2:0] (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in ({vout_vs, vin2_vs, vin1_vs}),
    .pulse    (vs_pulse)
  );

  always_comb begin
    elig         = '0;
    elig[CH_WR0] = bus.wr0_level >= LVL_MIN;
    elig[CH_WR1] = bus.wr1_level >= LVL_MIN;
    elig[CH_RD0] = bus.rd0_space >= LVL_MIN;
    elig[CH_RD1] = bus.rd1_space >= LVL_MIN;
    if (!init_done) elig = '0;
  end

  always_comb begin
    win   = rr;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = rr + 2'(k);
      if (!found && elig[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Restarts land only when no burst owns the offsets; same-cycle DONE is overridden below.
  assign can_apply = (state == IDLE) || (state == DONE);
  assign wr_apply  = can_apply ? (wr_pend | vs_pulse[1:0]) : 2'b00;
  assign rd_apply  = can_apply & (rd_pend | vs_pulse[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend <= '0;
      rd_pend <= 1'b0;
    end else begin
      wr_pend <= (wr_pend | vs_pulse[1:0]) & ~wr_apply;
      rd_pend <= (rd_pend | vs_pulse[2]) & ~rd_apply;
    end
  end

`ifdef DDR_SCHED_DOUBLE_BUF_EN
  logic [1:0] wr_bank, rd_bank;
  logic       win_bank;

  // Readers restart on the bank the writer just finished, i.e. opposite its new bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= '0;
      rd_bank <= '0;
    end else begin
      wr_bank <= wr_bank ^ wr_apply;
      if (rd_apply) rd_bank <= ~(wr_bank ^ wr_apply);
    end
  end

  assign win_bank = win[1] ? rd_bank[win[0]] : wr_bank[win[0]];
  assign win_addr = (win[0] ? CH1_BASE : CH0_BASE) + (win_bank ? BANK_BYTES : '0)
                  + (ADDR_W'(off[win]) << 3);
`else
  assign win_addr = (win[0] ? CH1_BASE : CH0_BASE) + (ADDR_W'(off[win]) << 3);
`endif

  assign off_inc = off[ch] + OFF_STEP;
  assign off_nxt = (off_inc == OFF_END) ? '0 : off_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ch       <= CH_WR0;
      rr       <= '0;
      off      <= '0;
      xfer_req <= 1'b0;
      instr    <= INSTR_WR;
      cmd_addr <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|elig) begin
          state <= ARB;
          busy  <= 1'b1;
        end
        ARB: if (|elig) begin
          ch       <= win;
          instr    <= win[1] ? INSTR_RD : INSTR_WR;
          cmd_addr <= win_addr;
          if (win[1]) state <= R_CMD;
          else begin
            state    <= W_XFER;
            xfer_req <= 1'b1;
          end
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        W_XFER: if (bus.xfer_done) begin
          xfer_req <= 1'b0;
          state    <= W_CMD;
        end
        W_CMD: if (!bus.cmd_full) state <= DONE;
        R_CMD: if (!bus.cmd_full) begin
          state    <= R_XFER;
          xfer_req <= 1'b1;
        end
        R_XFER: if (bus.xfer_done) begin
          xfer_req <= 1'b0;
          state    <= DONE;
        end
        DONE: begin
          off[ch] <= off_nxt;
          rr      <= ch + 2'd1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
      for (int i = 0; i < 2; i++)
        if (wr_apply[i]) off[i] <= '0;
      if (rd_apply) begin
        off[CH_RD0] <= '0;
        off[CH_RD1] <= '0;
      end
    end
  end

  // Strobe follows cmd_full combinationally so it is never raised into a full FIFO.
  assign bus.cmd_en        = ((state == W_CMD) || (state == R_CMD)) && !bus.cmd_full;
  assign bus.xfer_req      = xfer_req;
  assign bus.xfer_ch       = ch;
  assign bus.cmd_instr     = instr;
  assign bus.cmd_bl        = 6'(BURST_LEN - 1);
  assign bus.cmd_byte_addr = cmd_addr;
  assign bus.busy          = busy;
endmodule
